// File: rtl/fetch_ctrl.sv
// Instruction fetch controller: drives the PC next-value, handshakes the instruction memory and buffers one word for decode.
// Optional misaligned-redirect trap is enabled by defining FETCH_TRAP_EN.
module fetch_ctrl #(
  parameter logic [31:0] RESET_VECTOR = 32'h0000_0000,
  parameter logic [31:0] TRAP_VECTOR  = 32'h0000_0004
) (
  input  logic        clk_i,
  input  logic        reset_i,
  input  logic [31:0] pc_i,
  output logic [31:0] pc_next_o,
  output logic        imem_req_o,
  output logic [31:0] imem_addr_o,
  input  logic        imem_ack_i,
  input  logic [31:0] imem_data_i,
  output logic [31:0] instr_o,
  output logic [31:0] instr_pc_o,
  output logic        instr_valid_o,
  input  logic        instr_ready_i,
  input  logic        redirect_i,
  input  logic [31:0] redirect_addr_i,
  output logic        misalign_o
);

  typedef enum logic [1:0] {S_START, S_FETCH, S_HOLD, S_FLUSH} state_t;

  state_t      state_q, state_d;
  logic [31:0] instr_q, instr_d;
  logic [31:0] instr_pc_q, instr_pc_d;
  logic [31:0] pending_q, pending_d;
  logic [31:0] pc_next_d;
  logic [31:0] redir_tgt;

`ifdef FETCH_TRAP_EN
  logic redir_bad;
  logic misalign_q;
  assign redir_bad = (redirect_addr_i[1:0] != 2'b00);
  assign redir_tgt = redir_bad ? TRAP_VECTOR : redirect_addr_i;
  assign misalign_o = misalign_q;

  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) misalign_q <= 1'b0;
    else         misalign_q <= redirect_i && redir_bad;
  end
`else
  assign redir_tgt  = redirect_addr_i & ~32'h0000_0003;
  assign misalign_o = 1'b0;
`endif

  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      state_q    <= S_START;
      instr_q    <= 32'h0;
      instr_pc_q <= 32'h0;
      pending_q  <= 32'h0;
    end else begin
      state_q    <= state_d;
      instr_q    <= instr_d;
      instr_pc_q <= instr_pc_d;
      pending_q  <= pending_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    instr_d    = instr_q;
    instr_pc_d = instr_pc_q;
    pending_d  = pending_q;
    pc_next_d  = pc_i;
    case (state_q)
      S_START: begin
        state_d = S_FETCH;
        if (redirect_i) pc_next_d = redir_tgt;
      end
      S_FETCH: begin
        if (redirect_i) begin
          // Without an ack the request is still in flight, so the target waits until it completes.
          if (imem_ack_i) pc_next_d = redir_tgt;
          else begin
            pending_d = redir_tgt;
            state_d   = S_FLUSH;
          end
        end else if (imem_ack_i) begin
          instr_d    = imem_data_i;
          instr_pc_d = pc_i;
          pc_next_d  = pc_i + 32'd4;
          state_d    = S_HOLD;
        end
      end
      S_FLUSH: begin
        if (redirect_i) pending_d = redir_tgt;
        if (imem_ack_i) begin
          pc_next_d = redirect_i ? redir_tgt : pending_q;
          state_d   = S_FETCH;
        end
      end
      S_HOLD: begin
        if (redirect_i) begin
          pc_next_d = redir_tgt;
          state_d   = S_FETCH;
        end else if (instr_ready_i) begin
          state_d = S_FETCH;
        end
      end
      default: state_d = S_START;
    endcase
  end

  always_comb begin
    imem_req_o    = (state_q == S_FETCH) || (state_q == S_FLUSH);
    instr_valid_o = (state_q == S_HOLD);
    pc_next_o     = reset_i ? RESET_VECTOR : pc_next_d;
    imem_addr_o   = pc_i;
    instr_o       = instr_q;
    instr_pc_o    = instr_pc_q;
  end

endmodule

// File: tb/tb_fetch_ctrl.sv
// Directed bench for fetch_ctrl with an external PC register and a memory returning ~address.
module tb_fetch_ctrl;
  logic        clk_i = 1'b0;
  logic        reset_i;
  logic [31:0] pc_q;
  logic [31:0] pc_next_o;
  logic        imem_req_o;
  logic [31:0] imem_addr_o;
  logic        imem_ack_i;
  logic [31:0] imem_data_i;
  logic [31:0] instr_o, instr_pc_o;
  logic        instr_valid_o, instr_ready_i;
  logic        redirect_i;
  logic [31:0] redirect_addr_i;
  logic        misalign_o;
  int          n_cmp = 0;
  int          n_bad = 0;

  always #5 clk_i = ~clk_i;

  always_ff @(posedge clk_i or posedge reset_i)
    if (reset_i) pc_q <= 32'h0;
    else         pc_q <= pc_next_o;

  assign imem_data_i = ~imem_addr_o;

  fetch_ctrl dut (
    .clk_i(clk_i), .reset_i(reset_i), .pc_i(pc_q), .pc_next_o(pc_next_o),
    .imem_req_o(imem_req_o), .imem_addr_o(imem_addr_o), .imem_ack_i(imem_ack_i),
    .imem_data_i(imem_data_i), .instr_o(instr_o), .instr_pc_o(instr_pc_o),
    .instr_valid_o(instr_valid_o), .instr_ready_i(instr_ready_i),
    .redirect_i(redirect_i), .redirect_addr_i(redirect_addr_i), .misalign_o(misalign_o)
  );

  task automatic tick();
    @(posedge clk_i);
    #1;
  endtask

  task automatic do_reset();
    reset_i = 1'b1; imem_ack_i = 1'b0; instr_ready_i = 1'b0;
    redirect_i = 1'b0; redirect_addr_i = 32'h0;
    tick();
    reset_i = 1'b0;
  endtask

  // Leaves the DUT in S_FETCH with pc = 4*n and ack deasserted.
  task automatic run_to_fetch(input int n);
    do_reset();
    imem_ack_i = 1'b1; instr_ready_i = 1'b1;
    tick();
    repeat (n) begin tick(); tick(); end
    imem_ack_i = 1'b0; instr_ready_i = 1'b0;
    #1;
  endtask

  task automatic test_reset();
    reset_i = 1'b1; imem_ack_i = 1'b1; instr_ready_i = 1'b0;
    redirect_i = 1'b0; redirect_addr_i = 32'h0;
    #2;
    n_cmp++; if (imem_req_o !== 1'b0) begin n_bad++; $display("FAIL rst_req got %b want 0", imem_req_o); end
    n_cmp++; if (instr_valid_o !== 1'b0) begin n_bad++; $display("FAIL rst_valid got %b want 0", instr_valid_o); end
    n_cmp++; if (instr_o !== 32'h0) begin n_bad++; $display("FAIL rst_instr got %h want 0", instr_o); end
    n_cmp++; if (instr_pc_o !== 32'h0) begin n_bad++; $display("FAIL rst_instr_pc got %h want 0", instr_pc_o); end
    n_cmp++; if (pc_next_o !== 32'h0) begin n_bad++; $display("FAIL rst_pc_next got %h want 0", pc_next_o); end
    n_cmp++; if (misalign_o !== 1'b0) begin n_bad++; $display("FAIL rst_misalign got %b want 0", misalign_o); end
    tick();
  endtask

  task automatic test_stream();
    do_reset();
    imem_ack_i = 1'b1; instr_ready_i = 1'b1;
    #1;
    n_cmp++; if (imem_req_o !== 1'b0) begin n_bad++; $display("FAIL start_req got %b want 0", imem_req_o); end
    tick();
    for (int i = 0; i < 4; i++) begin
      n_cmp++; if (imem_req_o !== 1'b1 || imem_addr_o !== 32'(4*i) || instr_valid_o !== 1'b0) begin
        n_bad++; $display("FAIL stream_fetch%0d req=%b addr=%h valid=%b want 1 %h 0", i, imem_req_o, imem_addr_o, instr_valid_o, 4*i); end
      n_cmp++; if (pc_next_o !== 32'(4*i+4)) begin n_bad++; $display("FAIL stream_pcnext%0d got %h want %h", i, pc_next_o, 4*i+4); end
      tick();
      n_cmp++; if (instr_valid_o !== 1'b1 || imem_req_o !== 1'b0 || instr_pc_o !== 32'(4*i) || instr_o !== ~32'(4*i)) begin
        n_bad++; $display("FAIL stream_hold%0d valid=%b req=%b ipc=%h instr=%h want 1 0 %h %h", i, instr_valid_o, imem_req_o, instr_pc_o, instr_o, 4*i, ~32'(4*i)); end
      tick();
    end
  endtask

  task automatic test_ack_delay();
    run_to_fetch(2);
    for (int i = 0; i < 3; i++) begin
      n_cmp++; if (imem_req_o !== 1'b1 || imem_addr_o !== 32'h8 || pc_next_o !== 32'h8 || instr_valid_o !== 1'b0) begin
        n_bad++; $display("FAIL ackdly_wait%0d req=%b addr=%h pcn=%h valid=%b want 1 8 8 0", i, imem_req_o, imem_addr_o, pc_next_o, instr_valid_o); end
      tick();
    end
    imem_ack_i = 1'b1; #1;
    n_cmp++; if (pc_next_o !== 32'hC) begin n_bad++; $display("FAIL ackdly_pcnext got %h want c", pc_next_o); end
    tick();
    n_cmp++; if (instr_valid_o !== 1'b1 || instr_pc_o !== 32'h8) begin
      n_bad++; $display("FAIL ackdly_hold valid=%b ipc=%h want 1 8", instr_valid_o, instr_pc_o); end
  endtask

  task automatic test_hold_stall();
    run_to_fetch(1);
    imem_ack_i = 1'b1;
    tick();
    for (int i = 0; i < 4; i++) begin
      n_cmp++; if (instr_valid_o !== 1'b1 || instr_pc_o !== 32'h4 || instr_o !== ~32'h4 || imem_req_o !== 1'b0 || pc_next_o !== 32'h8) begin
        n_bad++; $display("FAIL stall%0d valid=%b ipc=%h instr=%h req=%b pcn=%h want 1 4 fffffffb 0 8", i, instr_valid_o, instr_pc_o, instr_o, imem_req_o, pc_next_o); end
      tick();
    end
    instr_ready_i = 1'b1;
    tick();
    n_cmp++; if (imem_req_o !== 1'b1 || imem_addr_o !== 32'h8 || instr_valid_o !== 1'b0) begin
      n_bad++; $display("FAIL stall_release req=%b addr=%h valid=%b want 1 8 0", imem_req_o, imem_addr_o, instr_valid_o); end
  endtask

  task automatic test_redirect_flush();
    run_to_fetch(4);
    redirect_i = 1'b1; redirect_addr_i = 32'h100; #1;
    n_cmp++; if (pc_next_o !== 32'h10) begin n_bad++; $display("FAIL flush_pchold got %h want 10", pc_next_o); end
    tick();
    redirect_i = 1'b0; #1;
    n_cmp++; if (imem_req_o !== 1'b1 || imem_addr_o !== 32'h10 || instr_valid_o !== 1'b0) begin
      n_bad++; $display("FAIL flush_wait req=%b addr=%h valid=%b want 1 10 0", imem_req_o, imem_addr_o, instr_valid_o); end
    imem_ack_i = 1'b1; #1;
    n_cmp++; if (pc_next_o !== 32'h100) begin n_bad++; $display("FAIL flush_pcnext got %h want 100", pc_next_o); end
    tick();
    imem_ack_i = 1'b0; #1;
    n_cmp++; if (imem_req_o !== 1'b1 || imem_addr_o !== 32'h100 || instr_valid_o !== 1'b0) begin
      n_bad++; $display("FAIL flush_refetch req=%b addr=%h valid=%b want 1 100 0", imem_req_o, imem_addr_o, instr_valid_o); end
  endtask

  task automatic test_flush_overwrite();
    run_to_fetch(1);
    redirect_i = 1'b1; redirect_addr_i = 32'h100;
    tick();
    redirect_addr_i = 32'h200;
    tick();
    redirect_i = 1'b0; imem_ack_i = 1'b1; #1;
    n_cmp++; if (pc_next_o !== 32'h200) begin n_bad++; $display("FAIL overwrite_pending got %h want 200", pc_next_o); end
    redirect_i = 1'b1; redirect_addr_i = 32'h300; #1;
    n_cmp++; if (pc_next_o !== 32'h300) begin n_bad++; $display("FAIL overwrite_live got %h want 300", pc_next_o); end
    tick();
    redirect_i = 1'b0; imem_ack_i = 1'b0; #1;
    n_cmp++; if (imem_addr_o !== 32'h300 || imem_req_o !== 1'b1) begin
      n_bad++; $display("FAIL overwrite_fetch addr=%h req=%b want 300 1", imem_addr_o, imem_req_o); end
  endtask

  task automatic test_redirect_with_ack();
    run_to_fetch(0);
    imem_ack_i = 1'b1; redirect_i = 1'b1; redirect_addr_i = 32'h40; #1;
    n_cmp++; if (pc_next_o !== 32'h40) begin n_bad++; $display("FAIL redack_pcnext got %h want 40", pc_next_o); end
    tick();
    imem_ack_i = 1'b0; redirect_i = 1'b0; #1;
    n_cmp++; if (instr_valid_o !== 1'b0 || imem_req_o !== 1'b1 || imem_addr_o !== 32'h40) begin
      n_bad++; $display("FAIL redack_state valid=%b req=%b addr=%h want 0 1 40", instr_valid_o, imem_req_o, imem_addr_o); end
  endtask

  task automatic test_misalign();
    logic [31:0] exp_tgt;
    logic        exp_mis;
`ifdef FETCH_TRAP_EN
    exp_tgt = 32'h4; exp_mis = 1'b1;
`else
    exp_tgt = 32'h100; exp_mis = 1'b0;
`endif
    run_to_fetch(1);
    imem_ack_i = 1'b1;
    tick();
    imem_ack_i = 1'b0; redirect_i = 1'b1; redirect_addr_i = 32'h102; #1;
    n_cmp++; if (pc_next_o !== exp_tgt) begin n_bad++; $display("FAIL mis_pcnext got %h want %h", pc_next_o, exp_tgt); end
    tick();
    redirect_i = 1'b0; #1;
    n_cmp++; if (imem_addr_o !== exp_tgt || instr_valid_o !== 1'b0 || misalign_o !== exp_mis) begin
      n_bad++; $display("FAIL mis_fetch addr=%h valid=%b mis=%b want %h 0 %b", imem_addr_o, instr_valid_o, misalign_o, exp_tgt, exp_mis); end
    tick();
    n_cmp++; if (misalign_o !== 1'b0) begin n_bad++; $display("FAIL mis_pulse_end got %b want 0", misalign_o); end
  endtask

  task automatic test_wrap_and_reset();
    do_reset();
    redirect_i = 1'b1; redirect_addr_i = 32'hFFFF_FFFC; #1;
    n_cmp++; if (pc_next_o !== 32'hFFFF_FFFC) begin n_bad++; $display("FAIL wrap_start_redir got %h want fffffffc", pc_next_o); end
    tick();
    redirect_i = 1'b0; imem_ack_i = 1'b1; #1;
    n_cmp++; if (pc_next_o !== 32'h0) begin n_bad++; $display("FAIL wrap_pcnext got %h want 0", pc_next_o); end
    tick();
    n_cmp++; if (instr_pc_o !== 32'hFFFF_FFFC || instr_valid_o !== 1'b1) begin
      n_bad++; $display("FAIL wrap_hold ipc=%h valid=%b want fffffffc 1", instr_pc_o, instr_valid_o); end
    instr_ready_i = 1'b1;
    tick();
    imem_ack_i = 1'b0; #1;
    n_cmp++; if (imem_req_o !== 1'b1 || imem_addr_o !== 32'h0) begin
      n_bad++; $display("FAIL wrap_refetch req=%b addr=%h want 1 0", imem_req_o, imem_addr_o); end
    reset_i = 1'b1; #1;
    n_cmp++; if (imem_req_o !== 1'b0 || instr_valid_o !== 1'b0 || pc_next_o !== 32'h0) begin
      n_bad++; $display("FAIL midrst req=%b valid=%b pcn=%h want 0 0 0", imem_req_o, instr_valid_o, pc_next_o); end
    imem_ack_i = 1'b1;
    tick();
    reset_i = 1'b0; #1;
    n_cmp++; if (imem_req_o !== 1'b0 || instr_valid_o !== 1'b0 || pc_next_o !== 32'h0) begin
      n_bad++; $display("FAIL late_ack req=%b valid=%b pcn=%h want 0 0 0", imem_req_o, instr_valid_o, pc_next_o); end
    tick();
    n_cmp++; if (imem_req_o !== 1'b1 || imem_addr_o !== 32'h0) begin
      n_bad++; $display("FAIL restart req=%b addr=%h want 1 0", imem_req_o, imem_addr_o); end
  endtask

  initial begin
    test_reset();
    test_stream();
    test_ack_delay();
    test_hold_stall();
    test_redirect_flush();
    test_flush_overwrite();
    test_redirect_with_ack();
    test_misalign();
    test_wrap_and_reset();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule

// File: doc/fetch_ctrl.md
FETCH_CTRL -- requirements
Module: fetch_ctrl

Interface
REQ-001 Parameter RESET_VECTOR, 32'h00000000: PC value after reset; SHALL equal the program counter register's reset value.
REQ-002 Parameter TRAP_VECTOR, 32'h00000004: redirect target on misaligned redirect (FETCH_TRAP_EN only).
REQ-003 clk_i  in  1  clock; reset is reset_i, asynchronous, active-high; clock is clk_i.
REQ-004 reset_i  in  1  asynchronous active-high reset.
REQ-005 pc_i  in  32  current PC from program counter register.
REQ-006 pc_next_o  out  32  next PC, combinational, to program counter address input, which loads every clk_i.
REQ-007 imem_req_o  out  1  instruction memory request.
REQ-008 imem_addr_o  out  32  fetch address; equals pc_i.
REQ-009 imem_ack_i  in  1  memory ack; data valid same cycle.
REQ-010 imem_data_i  in  32  fetched instruction word.
REQ-011 instr_o / instr_pc_o  out  32 each  buffered instruction and its address.
REQ-012 instr_valid_o  out  1  instr_o valid; instr_ready_i  in  1  decode accepts.
REQ-013 redirect_i  in  1, redirect_addr_i  in  32  branch/jump redirect request and target.
REQ-014 misalign_o  out  1  one-cycle pulse on misaligned redirect (FETCH_TRAP_EN only; else tied 0).

Function
REQ-015 States SHALL be S_START, S_FETCH, S_HOLD, S_FLUSH.
REQ-016 pc_next_o SHALL equal pc_i in every case not listed in REQ-017..REQ-023 (PC holds).
REQ-017 S_START: no request; next cycle S_FETCH; redirect_i here sets pc_next_o=redirect_addr_i.
REQ-018 S_FETCH: imem_req_o=1; on imem_ack_i without redirect_i, capture imem_data_i into instr_o, pc_i into instr_pc_o, pc_next_o=pc_i+4 (mod 2^32, wraps 32'hFFFFFFFC->0), go S_HOLD.
REQ-019 S_FETCH, redirect_i with imem_ack_i same cycle: discard data, pc_next_o=redirect_addr_i, stay S_FETCH.
REQ-020 S_FETCH, redirect_i without ack: latch redirect_addr_i to pending register, PC holds, go S_FLUSH.
REQ-021 S_FLUSH: imem_req_o=1, address unchanged; a new redirect_i overwrites pending; on imem_ack_i discard data, pc_next_o=pending (or redirect_addr_i if redirect_i that cycle), go S_FETCH.
REQ-022 S_HOLD: instr_valid_o=1, instr_o/instr_pc_o stable; instr_ready_i -> S_FETCH; redirect_i (priority over ready) -> drop valid, pc_next_o=redirect_addr_i, S_FETCH.
REQ-023 imem_addr_o SHALL stay constant while imem_req_o=1 and no ack; imem_req_o SHALL never drop before ack.
REQ-024 instr_valid_o SHALL be 0 in all states except S_HOLD.
REQ-025 Peak throughput: one instruction per two cycles with zero-wait memory.

Reset
REQ-026 reset_i asynchronously forces S_START, instr_valid_o=0, imem_req_o=0, instr_o=0, instr_pc_o=0, pending=0, misalign_o=0; pc_next_o=RESET_VECTOR while reset_i high.
REQ-027 Reset mid-request abandons the transaction; a late ack after reset is ignored (S_START does not sample ack).

Configuration
REQ-028 Macro FETCH_TRAP_EN defined: any redirect target with bits [1:0]!=0 SHALL be replaced by TRAP_VECTOR and pulse misalign_o for one cycle.
REQ-029 FETCH_TRAP_EN undefined: redirect target bits [1:0] SHALL be forced to 0; misalign_o tied 0.

Verification
REQ-030 Reset release, zero-wait memory, ready always 1 -> fetch addresses 0,4,8,C; instr_valid_o every second cycle.
REQ-031 imem_ack_i delayed 3 cycles -> imem_req_o and imem_addr_o=0x8 stable for 3 cycles, PC holds at 0x8.
REQ-032 instr_ready_i low 4 cycles in S_HOLD -> instr_o, instr_pc_o=0x4 stable; no new request.
REQ-033 redirect to 0x100 during pending fetch of 0x10 -> ack data discarded, next request at 0x100, no instr_valid_o for 0x10.
REQ-034 redirect to 0x102: with FETCH_TRAP_EN -> next fetch 0x4, misalign_o pulses; without -> next fetch 0x100.
REQ-035 pc_i=0xFFFFFFFC fetch ack -> pc_next_o=0x0; reset asserted mid-request -> req drops immediately, restart at 0x0.
